// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants, FSM state type and GF(2^8) helpers
//                for the iterative AES-128 encryption core.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR = 10;

    // Round constants for the key schedule, first entry used for K1
    localparam logic [7:0] AES_RCON [AES_NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8) with the AES reduction polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product, shift-and-add over the bits of b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_enc_iter_rkey.sv
`default_nettype none
// ============================================================================
//  Module      : aes_rkey_gen128
//  Description : On-the-fly AES-128 key schedule. Holds the previous round
//                key; rkey presents its successor, which is the key applied
//                by the round in progress and becomes the stored key on step.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_rkey_gen128
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         Rst_n,
    input  logic         load,
    input  logic [127:0] key0,
    input  logic         step,
    output logic [127:0] rkey
);

    logic [127:0] r_rk;
    logic [3:0]   r_idx;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [7:0]   w_rcon;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;

    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_ksbox
        aes_sbox u_sbox (
            .din  (w_rot[8*k +: 8]),
            .dout (w_sub[8*k +: 8])
        );
    end

    // Index past the last round only occurs after round 10 and is never used
    assign w_rcon = (r_idx < 4'(AES_NR)) ? AES_RCON[r_idx] : 8'h00;
    assign w_t    = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0   = r_rk[127:96] ^ w_t;
    assign w_n1   = r_rk[95:64]  ^ w_n0;
    assign w_n2   = r_rk[63:32]  ^ w_n1;
    assign w_n3   = r_rk[31:0]   ^ w_n2;
    assign rkey   = {w_n0, w_n1, w_n2, w_n3};

    // Round-key register and Rcon index: load K0 on accept, advance per round
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rk  <= '0;
            r_idx <= '0;
        end else if (load) begin
            r_rk  <= key0;
            r_idx <= '0;
        end else if (step) begin
            r_rk  <= rkey;
            if (r_idx < 4'(AES_NR)) r_idx <= r_idx + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box: multiplicative inverse in
//                GF(2^8) (as x^254) followed by the affine transform.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] w_inv;

    // x^254 by repeated square-and-multiply: exponents 3,7,..,127 then square
    always_comb begin
        w_inv = din;
        for (int i = 0; i < 6; i++) begin
            w_inv = gf_mul(gf_mul(w_inv, w_inv), din);
        end
        w_inv = gf_mul(w_inv, w_inv);
    end

    assign dout = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/aes128_enc_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_enc_iter
//  Description : Iterative AES-128 encryption core. SBOX_LANES state bytes are
//                substituted per cycle; the round finishes (ShiftRows,
//                MixColumns, AddRoundKey) on the last phase. Key is stored
//                between blocks; in/key/out use valid-ready handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 4
)(
    input  logic         CLK,
    input  logic         Rst_n,
    input  logic         key_vld,
    input  logic [127:0] key,
    output logic         key_rdy,
    input  logic         in_vld,
    input  logic [127:0] in_data,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [127:0] out_data,
    input  logic         out_rdy,
    output logic         busy
);

    localparam int c_phases = 16 / SBOX_LANES;
    localparam int c_pw     = (c_phases > 1) ? $clog2(c_phases) : 1;
    localparam logic [c_pw-1:0] c_last_ph = c_pw'(c_phases - 1);

    aes_state_e      r_fsm;
    aes_state_e      w_fsm_nxt;
    logic [127:0]    r_key;
    logic [127:0]    r_st;
    logic [127:0]    r_out;
    logic [7:0]      r_sub_b [16];
    logic [c_pw-1:0] r_phase;
    logic [3:0]      r_round;

    logic            w_in_rdy;
    logic            w_accept;
    logic            w_key_ld;
    logic [127:0]    w_key_use;
    logic            w_last_ph;
    logic            w_step;
    logic            w_final;
    logic [127:0]    w_rkey;
    logic [127:0]    w_rnd;
    logic [7:0]      w_st_b   [16];
    logic [7:0]      w_full_b [16];
    logic [7:0]      w_sr_b   [16];
    logic [7:0]      w_mc_b   [16];
    logic [7:0]      w_lane_in  [SBOX_LANES];
    logic [7:0]      w_lane_out [SBOX_LANES];

    assign w_in_rdy  = (r_fsm == IDLE) | ((r_fsm == HOLD) & out_rdy);
    assign w_accept  = in_vld & w_in_rdy;
    assign w_key_ld  = key_vld & w_in_rdy;
    assign w_key_use = w_key_ld ? key : r_key;
    assign w_last_ph = (r_phase == c_last_ph);
    assign w_step    = (r_fsm == RUN) & w_last_ph;
    assign w_final   = w_step & (r_round == 4'(AES_NR));

    assign in_rdy   = w_in_rdy;
    assign key_rdy  = w_in_rdy;
    assign out_vld  = (r_fsm == HOLD);
    assign busy     = (r_fsm == RUN);
    assign out_data = r_out;

    aes_rkey_gen128 u_rkey (
        .CLK   (CLK),
        .Rst_n (Rst_n),
        .load  (w_accept),
        .key0  (w_key_use),
        .step  (w_step),
        .rkey  (w_rkey)
    );

    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        assign w_lane_in[j] = w_st_b[4'(int'(r_phase) * SBOX_LANES + j)];
        aes_sbox u_sbox (
            .din  (w_lane_in[j]),
            .dout (w_lane_out[j])
        );
    end

    // Byte view of the state register, byte 0 in the top bits
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_st_b[i] = r_st[127-8*i -: 8];
        end
    end

    // Sub-bytes buffer with this cycle's lane outputs merged into their slot
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_full_b[i] = r_sub_b[i];
            if ((i / SBOX_LANES) == int'(r_phase)) begin
                w_full_b[i] = w_lane_out[i % SBOX_LANES];
            end
        end
    end

    // ShiftRows, MixColumns (bypassed in the final round), AddRoundKey
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr_b[r + 4*c] = w_full_b[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (r_round == 4'(AES_NR)) begin
                for (int r = 0; r < 4; r++) w_mc_b[r + 4*c] = w_sr_b[r + 4*c];
            end else begin
                w_mc_b[4*c+0] = xtime(w_sr_b[4*c+0]) ^ xtime(w_sr_b[4*c+1]) ^ w_sr_b[4*c+1]
                              ^ w_sr_b[4*c+2] ^ w_sr_b[4*c+3];
                w_mc_b[4*c+1] = w_sr_b[4*c+0] ^ xtime(w_sr_b[4*c+1]) ^ xtime(w_sr_b[4*c+2])
                              ^ w_sr_b[4*c+2] ^ w_sr_b[4*c+3];
                w_mc_b[4*c+2] = w_sr_b[4*c+0] ^ w_sr_b[4*c+1] ^ xtime(w_sr_b[4*c+2])
                              ^ xtime(w_sr_b[4*c+3]) ^ w_sr_b[4*c+3];
                w_mc_b[4*c+3] = xtime(w_sr_b[4*c+0]) ^ w_sr_b[4*c+0] ^ w_sr_b[4*c+1]
                              ^ w_sr_b[4*c+2] ^ xtime(w_sr_b[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            w_rnd[127-8*i -: 8] = w_mc_b[i] ^ w_rkey[127-8*i -: 8];
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    // FSM next-state decode
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (w_accept) w_fsm_nxt = RUN;
            RUN:     if (w_final)  w_fsm_nxt = HOLD;
            HOLD:    if (out_rdy)  w_fsm_nxt = in_vld ? RUN : IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Key store, cipher state, phase/round counters and result register
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_key   <= '0;
            r_st    <= '0;
            r_out   <= '0;
            r_phase <= '0;
            r_round <= 4'd0;
            for (int i = 0; i < 16; i++) r_sub_b[i] <= 8'h00;
        end else begin
            if (w_key_ld) r_key <= key;
            if (w_accept) begin
                r_st    <= in_data ^ w_key_use;
                r_round <= 4'd1;
                r_phase <= '0;
            end else if (r_fsm == RUN) begin
                r_sub_b <= w_full_b;
                if (w_last_ph) begin
                    r_st    <= w_rnd;
                    r_phase <= '0;
                    if (!w_final) r_round <= r_round + 4'd1;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end
            if (w_final) r_out <= w_rnd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes128_enc_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_enc_iter
//  Description : Self-checking bench for aes128_enc_iter. Three instances
//                (4, 1 and 16 lanes) share clock, reset and data buses;
//                results are checked against known vectors and a
//                textbook AES-128 reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes128_enc_iter;

    logic         CLK;
    logic         Rst_n;
    logic [127:0] key_bus;
    logic [127:0] in_bus;
    logic         key_vld  [3];
    logic         in_vld   [3];
    logic         out_rdy  [3];
    logic         key_rdy  [3];
    logic         in_rdy   [3];
    logic         out_vld  [3];
    logic         busy     [3];
    logic [127:0] out_data [3];

    int           n_cmp;
    int           n_mis;
    logic [7:0]   sbox_t [256];
    int           exp_lat [3];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int c_l = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        aes128_enc_iter #(.SBOX_LANES(c_l)) u_dut (
            .CLK      (CLK),
            .Rst_n    (Rst_n),
            .key_vld  (key_vld[g]),
            .key      (key_bus),
            .key_rdy  (key_rdy[g]),
            .in_vld   (in_vld[g]),
            .in_data  (in_bus),
            .in_rdy   (in_rdy[g]),
            .out_vld  (out_vld[g]),
            .out_data (out_data[g]),
            .out_rdy  (out_rdy[g]),
            .busy     (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] cst;
        logic [7:0] o;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ cst[i];
            end
            sbox_t[x] = o;
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                    ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row+4*c] = s[row + 4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        s[row+4*c] = gmul(8'h02, t[row+4*c]) ^ gmul(8'h03, t[(row+1)%4+4*c])
                                   ^ t[(row+2)%4+4*c] ^ t[(row+3)%4+4*c];
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_block(input int d, input logic [127:0] k, input bit ld,
                               input logic [127:0] pt);
        int n;
        @(negedge CLK);
        key_bus = k; in_bus = pt; key_vld[d] = ld; in_vld[d] = 1'b1;
        n = 0;
        while (!in_rdy[d] && n < 500) begin @(negedge CLK); n++; end
        if (n >= 500) chk("accept_timeout", 128'(n), 128'd0);
        @(posedge CLK); #1;
        key_vld[d] = 1'b0; in_vld[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int lat);
        lat = 0;
        while (!out_vld[d] && lat < 400) begin @(posedge CLK); #1; lat++; end
        if (lat >= 400) chk("out_timeout", 128'(lat), 128'd0);
    endtask

    task automatic run_block(input int d, input logic [127:0] k, input bit ld,
                             input logic [127:0] pt, output logic [127:0] ct, output int lat);
        start_block(d, k, ld, pt);
        wait_out(d, lat);
        ct = out_data[d];
    endtask

    task automatic pop(input int d);
        @(negedge CLK); out_rdy[d] = 1'b1;
        @(posedge CLK); #1; out_rdy[d] = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_vld"},  128'(out_vld[0]), 128'd0);
        chk({tag, "_busy"}, 128'(busy[0]),    128'd0);
        chk({tag, "_irdy"}, 128'(in_rdy[0]),  128'd1);
        chk({tag, "_krdy"}, 128'(key_rdy[0]), 128'd1);
        chk({tag, "_data"}, out_data[0],      128'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, k1, p1, e1, k2, ka, kb, pt, pt2, held;
        int lat, seen;
        n_cmp = 0; n_mis = 0;
        exp_lat = '{40, 160, 10};
        for (int d = 0; d < 3; d++) begin
            key_vld[d] = 1'b0; in_vld[d] = 1'b0; out_rdy[d] = 1'b0;
        end
        key_bus = '0; in_bus = '0;
        Rst_n = 1'b0;
        build_sbox();
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        p1 = 128'h00112233445566778899aabbccddeeff;
        e1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        repeat (3) @(posedge CLK);
        #1 chk_reset_outs("rst_in");
        @(negedge CLK) Rst_n = 1'b1;
        @(negedge CLK) chk_reset_outs("rst_out");

        // FIPS-197 C.1 with latency, all three lane counts
        for (int d = 0; d < 3; d++) begin
            run_block(d, k1, 1'b1, p1, ct, lat);
            chk($sformatf("c1_ct_%0d", d), ct, e1);
            chk($sformatf("c1_lat_%0d", d), 128'(lat), 128'(exp_lat[d]));
            pop(d);
        end

        // SP800-38A ECB, then CMAC L and a further block on the stored key
        run_block(0, k2, 1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, ct, lat);
        chk("ecb", ct, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
        pop(0);
        run_block(0, '0, 1'b0, 128'h0, ct, lat);
        chk("cmac_l", ct, 128'h7df76b0c1ab899b33e42f047b91b546f);
        pop(0);
        pt = rnd128();
        run_block(0, '0, 1'b0, pt, ct, lat);
        chk("stored_key", ct, ref_enc(k2, pt));
        pop(0);

        // Random keys and blocks, new key accepted with the block
        for (int i = 0; i < 4; i++) begin
            ka = rnd128(); pt = rnd128();
            run_block(0, ka, 1'b1, pt, ct, lat);
            chk("rand_ct", ct, ref_enc(ka, pt));
            pop(0);
        end

        // Backpressure then pop-and-accept in the same cycle
        ka = rnd128(); pt = rnd128(); pt2 = rnd128();
        run_block(0, ka, 1'b1, pt, held, lat);
        chk("bp_first", held, ref_enc(ka, pt));
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK); #1;
            chk("bp_data", out_data[0], held);
            chk("bp_irdy", 128'(in_rdy[0]), 128'd0);
            chk("bp_vld",  128'(out_vld[0]), 128'd1);
        end
        @(negedge CLK);
        in_bus = pt2; in_vld[0] = 1'b1; out_rdy[0] = 1'b1;
        #1 chk("bb_irdy", 128'(in_rdy[0]), 128'd1);
        @(posedge CLK); #1;
        in_vld[0] = 1'b0; out_rdy[0] = 1'b0;
        chk("bb_vld_drop", 128'(out_vld[0]), 128'd0);
        chk("bb_busy", 128'(busy[0]), 128'd1);
        wait_out(0, lat);
        chk("bb_lat", 128'(lat), 128'd40);
        chk("bb_ct", out_data[0], ref_enc(ka, pt2));
        pop(0);

        // key_vld during RUN is ignored
        kb = rnd128(); pt = rnd128();
        start_block(0, '0, 1'b0, pt);
        @(negedge CLK); key_bus = kb; key_vld[0] = 1'b1;
        chk("run_krdy", 128'(key_rdy[0]), 128'd0);
        repeat (5) @(negedge CLK);
        key_vld[0] = 1'b0;
        wait_out(0, lat);
        chk("run_key_ign", out_data[0], ref_enc(ka, pt));
        pop(0);
        pt = rnd128();
        run_block(0, '0, 1'b0, pt, ct, lat);
        chk("run_key_ign2", ct, ref_enc(ka, pt));
        pop(0);

        // Reset in round 5 aborts the block and clears the stored key
        start_block(0, k1, 1'b1, p1);
        repeat (18) @(posedge CLK);
        #2 Rst_n = 1'b0;
        #1 chk_reset_outs("mid_rst");
        @(negedge CLK); @(negedge CLK) Rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            if (out_vld[0]) seen++;
        end
        chk("mid_rst_novld", 128'(seen), 128'd0);
        pt = rnd128();
        run_block(0, '0, 1'b0, pt, ct, lat);
        chk("key_cleared", ct, ref_enc(128'h0, pt));
        pop(0);
        run_block(0, k1, 1'b1, p1, ct, lat);
        chk("post_rst_c1", ct, e1);
        chk("post_rst_lat", 128'(lat), 128'd40);
        pop(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes128_enc_iter.md
# aes128_enc_iter

Parametrised iterative AES-128 encryption core for the CMAC datapath, the successor to the fixed 4-S-box cipher. S-box parallelism is set by a parameter, trading area against cycles per round. Key and plaintext enter through valid/ready handshakes and the ciphertext leaves through one. The key is stored, so back-to-back blocks under the same key need no reload. The block sits between the CMAC message/subkey logic and the tag register.

## Interface
- SBOX_LANES, 4, number of state S-boxes used per cycle. Legal values are 1, 2, 4, 8, 16. Cycles per round are P = 16/SBOX_LANES.
- CLK  in  1  clock; everything is rising-edge.
- Rst_n  in  1  reset. Asynchronous assert, active-low.
- key_vld  in  1  a new cipher key is offered.
- key  in  128  cipher key, FIPS-197 byte order (byte 0 is bits 127:120).
- key_rdy  out  1  key can be accepted. Equals in_rdy.
- in_vld  in  1  a plaintext block is offered.
- in_data  in  128  plaintext, same byte order.
- in_rdy  out  1  the core can accept a block this cycle.
- out_vld  out  1  ciphertext is valid.
- out_data  out  128  ciphertext.
- out_rdy  in  1  the consumer accepts the ciphertext.
- busy  out  1  a block is in progress (state RUN).

## Operation
- FSM states and transitions:
  - IDLE: go to RUN on in_vld & in_rdy.
  - RUN: go to HOLD at the last phase of round 10.
  - HOLD: on out_rdy with no in_vld, go to IDLE. On out_rdy & in_vld, go directly to RUN.
- Ready and valid decode:
  - in_rdy = (IDLE) | (HOLD & out_rdy).
  - out_vld = HOLD.
  - busy = RUN.
- Key acceptance:
  - key_vld & key_rdy loads the key register.
  - If the key and a block are accepted in the same cycle, that block uses the new key.
  - key_vld outside key_rdy is ignored; no error.
- Block accept:
  - state ← in_data ^ K0.
  - The round-key generator loads K0.
  - round ← 1, phase ← 0.
- Each RUN cycle, phase p substitutes state bytes p·L … p·L+L−1 (L = SBOX_LANES) into a 16-byte sub-bytes buffer.
- On the cycle where phase = P−1, ShiftRows, MixColumns and AddRoundKey are applied to the buffer merged with the current lane outputs, and the result is written to the state register.
  - MixColumns is skipped in round 10.
  - The round-key generator steps (K_r → K_r+1) at the same edge.
  - round increments and phase wraps to 0.
- At the end of round 10, the result is written to out_data and the FSM enters HOLD.
- out_data stays stable while out_vld & !out_rdy.
- The round-key generator holds the current round key in a register. Each step computes the next key combinationally:
  - RotWord, then SubWord on its own 4 S-boxes, then XOR with Rcon.
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Arithmetic rules:
  - MixColumns uses xtime with the 0x1b reduction, GF(2^8).
  - The phase counter is max(1, clog2(P)) bits; at P = 1 it stays 0.
  - The round counter is 4 bits and runs 1..10.

## Timing
- Reset values:
  - Outputs: out_vld = 0, busy = 0, in_rdy = key_rdy = 1, out_data = 0.
  - Internal: key register, state and round key are 0; FSM is IDLE.
- Latency: acceptance at edge E0 gives out_vld high after edge E0 + 10·P.
  - SBOX_LANES = 4: 40 cycles.
  - SBOX_LANES = 16: 10 cycles.
  - SBOX_LANES = 1: 160 cycles.
- Throughput with out_rdy held high: one block per 10·P + 1 cycles. The HOLD cycle overlaps the next accept.
- Back-to-back: in HOLD, out_rdy & in_vld pops the old result and accepts the new block at the same edge. out_vld drops for exactly 10·P − 1 … 10·P cycles, never overlapping.
- No combinational path from in_vld to in_rdy. The only combinational path from out_rdy is to in_rdy and key_rdy.
- Reset asserted mid-block aborts the block immediately. No out_vld follows, and the stored key is cleared.

## Structure
- The shared package aes_pkg holds:
  - AES_NR = 10.
  - The Rcon constant array.
  - The xtime function.
  - A state-type enum {IDLE, RUN, HOLD}.
- Existing aes_sbox is reused: SBOX_LANES instances in the datapath plus 4 in the key generator.
- Sub-module aes_rkey_gen128 has ports CLK, Rst_n, load, key0, step, rkey[127:0].
  - It contains the Rcon index counter and the next-key logic.

## Test plan
- FIPS-197 C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a, out_vld exactly 10·P cycles after accept. Run for SBOX_LANES ∈ {1, 4, 16}.
- SP800-38A ECB: key 2b7e151628aed2a6abf7158809cf4f3c, pt 6bc1bee22e409f96e93d7e117393172a → 3ad77bb40d7a3660a89ecaf32466ef97.
- CMAC subkey L: same key, pt 0 → 7df76b0c1ab899b33e42f047b91b546f.
  - Then a second block is sent without reloading the key and must produce the correct result.
- Backpressure: out_rdy held low for 25 cycles.
  - out_data stays stable and in_rdy stays 0.
  - Then out_rdy & in_vld in the same cycle: the old result pops, the new block starts, and its result is correct.
- Simultaneous key_vld & in_vld with a new key: the block uses the new key. key_vld offered during RUN is ignored, and the next block still uses the old key.
- Rst_n pulsed low in round 5: outputs return to reset values asynchronously and no out_vld appears. After reset, a fresh key plus the C.1 vector gives the correct result.
